// File: rtl/program_loader.sv
// Boot loader: parses framed bytes into 32-bit words written to I-BRAM or D-BRAM,
// holding the core stalled until a RUN command is accepted.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for a target byte or the RUN command
// S_CNT_LO  | expecting the low byte of the word count
// S_CNT_HI  | expecting the high byte; range-checked against target depth
// S_PAYLOAD | collecting little-endian payload bytes, one word write per 4
// S_CHECK   | expecting the XOR checksum of the payload
// S_RUN     | core released; stream back-pressured (terminal)
// S_ERR     | fault seen; bytes discarded, no writes (terminal)
module program_loader #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          I_DEPTH    = 1024,
  parameter int          D_DEPTH    = 1024,
  parameter logic [7:0]  TGT_INSTR  = 8'hA5,
  parameter logic [7:0]  TGT_DATA   = 8'h5A,
  parameter logic [7:0]  CMD_RUN    = 8'hC3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_dat,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [31:0]           i_w_dat,
  output logic                  i_w_enb,
  output logic [3:0]            i_w_byte_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [31:0]           d_w_dat,
  output logic                  d_w_enb,
  output logic [3:0]            d_w_byte_enb,
  output logic                  pc_stall,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int MAX_DEPTH = (I_DEPTH > D_DEPTH) ? I_DEPTH : D_DEPTH;
  localparam int IDX_W     = $clog2(MAX_DEPTH) + 1;
  localparam logic [15:0] I_LIM = 16'(I_DEPTH);
  localparam logic [15:0] D_LIM = 16'(D_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_LO, S_CNT_HI, S_PAYLOAD, S_CHECK, S_RUN, S_ERR
  } state_t;

  state_t           state;
  logic             tgt_instr;
  logic [7:0]       cnt_lo;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [1:0]       k;
  logic [23:0]      word_buf;
  logic [7:0]       chk;

  logic             accept;
  logic [15:0]      cnt_full;
  logic [15:0]      lim;
  logic [IDX_W+1:0] addr_full;
  logic [IDX_W-1:0] idx_next;

  assign accept    = s_valid & s_ready;
  assign cnt_full  = {s_dat, cnt_lo};
  assign lim       = tgt_instr ? I_LIM : D_LIM;
  assign addr_full = {idx, 2'b00};
  assign idx_next  = idx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      tgt_instr    <= 1'b0;
      cnt_lo       <= '0;
      cnt          <= '0;
      idx          <= '0;
      k            <= '0;
      word_buf     <= '0;
      chk          <= '0;
      s_ready      <= 1'b0;
      i_w_addr     <= '0;
      i_w_dat      <= '0;
      i_w_enb      <= 1'b0;
      i_w_byte_enb <= '0;
      d_w_addr     <= '0;
      d_w_dat      <= '0;
      d_w_enb      <= 1'b0;
      d_w_byte_enb <= '0;
      pc_stall     <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      i_w_enb      <= 1'b0;
      d_w_enb      <= 1'b0;
      i_w_byte_enb <= '0;
      d_w_byte_enb <= '0;
      s_ready      <= (state != S_RUN);
      if (accept) begin
        case (state)
          S_IDLE: begin
            chk <= '0;
            idx <= '0;
            k   <= '0;
            if (s_dat == TGT_INSTR) begin
              tgt_instr <= 1'b1;
              state     <= S_CNT_LO;
            end else if (s_dat == TGT_DATA) begin
              tgt_instr <= 1'b0;
              state     <= S_CNT_LO;
            end else if (s_dat == CMD_RUN) begin
              state     <= S_RUN;
              pc_stall  <= 1'b0;
              load_done <= 1'b1;
              s_ready   <= 1'b0;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
          S_CNT_LO: begin
            cnt_lo <= s_dat;
            state  <= S_CNT_HI;
          end
          S_CNT_HI: begin
            if (cnt_full > lim) begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end else if (cnt_full == 16'd0) begin
              state <= S_CHECK;
            end else begin
              cnt   <= cnt_full[IDX_W-1:0];
              state <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            chk <= chk ^ s_dat;
            k   <= k + 2'd1;
            case (k)
              2'd0: word_buf[7:0]   <= s_dat;
              2'd1: word_buf[15:8]  <= s_dat;
              2'd2: word_buf[23:16] <= s_dat;
              default: begin
                // Write lands the cycle after the 4th byte, overlapping the next byte.
                if (tgt_instr) begin
                  i_w_addr     <= addr_full[ADDR_WIDTH-1:0];
                  i_w_dat      <= {s_dat, word_buf};
                  i_w_enb      <= 1'b1;
                  i_w_byte_enb <= 4'b1111;
                end else begin
                  d_w_addr     <= addr_full[ADDR_WIDTH-1:0];
                  d_w_dat      <= {s_dat, word_buf};
                  d_w_enb      <= 1'b1;
                  d_w_byte_enb <= 4'b1111;
                end
                idx <= idx_next;
                if (idx_next == cnt) state <= S_CHECK;
              end
            endcase
          end
          S_CHECK: begin
            if (s_dat == chk) begin
              state <= S_IDLE;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected BRAM writes go into a scoreboard queue,
// a negedge monitor pops and compares every write pulse the loader emits.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_dat = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [11:0] i_w_addr, d_w_addr;
  logic [31:0] i_w_dat, d_w_dat;
  logic        i_w_enb, d_w_enb;
  logic [3:0]  i_w_byte_enb, d_w_byte_enb;
  logic        pc_stall, load_done, load_err;

  typedef struct {
    bit          instr;
    logic [11:0] addr;
    logic [31:0] dat;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  program_loader dut (
    .clk(clk), .rst(rst),
    .s_dat(s_dat), .s_valid(s_valid), .s_ready(s_ready),
    .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb), .i_w_byte_enb(i_w_byte_enb),
    .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb), .d_w_byte_enb(d_w_byte_enb),
    .pc_stall(pc_stall), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Monitor: every write pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (i_w_enb && d_w_enb) begin
        n_cmp++; n_bad++;
        $display("FAIL both_enb: i_w_enb and d_w_enb both high at %0t", $time);
      end else if (i_w_enb || d_w_enb) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: instr=%0b addr=%h dat=%h, none expected",
                   i_w_enb, i_w_enb ? i_w_addr : d_w_addr, i_w_enb ? i_w_dat : d_w_dat);
        end else begin
          wr_t e;
          logic [11:0] a;
          logic [31:0] d;
          logic [3:0]  be;
          e  = exp_q.pop_front();
          a  = i_w_enb ? i_w_addr : d_w_addr;
          d  = i_w_enb ? i_w_dat : d_w_dat;
          be = i_w_enb ? i_w_byte_enb : d_w_byte_enb;
          if (i_w_enb != e.instr || a != e.addr || d != e.dat || be != 4'b1111) begin
            n_bad++;
            $display("FAIL write: got instr=%0b addr=%h dat=%h be=%b, want instr=%0b addr=%h dat=%h be=1111",
                     i_w_enb, a, d, be, e.instr, e.addr, e.dat);
          end
        end
      end else begin
        n_cmp++;
        if (i_w_byte_enb != 4'b0000 || d_w_byte_enb != 4'b0000) begin
          n_bad++;
          $display("FAIL idle_byte_enb: got i=%b d=%b, want 0000", i_w_byte_enb, d_w_byte_enb);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic push(input bit instr, input logic [11:0] addr, input logic [31:0] dat);
    wr_t e;
    e.instr = instr; e.addr = addr; e.dat = dat;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    s_dat = b;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!s_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: byte %h not accepted within 50 cycles", b);
    end else begin
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input bit rnd_gap);
    foreach (bytes[i]) send(bytes[i], rnd_gap ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic do_reset(input bit check_en);
    @(posedge clk); #1;
    rst = 1'b0;
    s_valid = 1'b0;
    #2;
    if (check_en) begin
      check("rst_s_ready", s_ready, 0);
      check("rst_enb", {i_w_enb, d_w_enb, i_w_byte_enb, d_w_byte_enb}, 0);
      check("rst_addr_dat", {i_w_addr, d_w_addr, i_w_dat ^ d_w_dat}, 0);
      check("rst_flags", {pc_stall, load_done, load_err}, 3'b100);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    if (check_en) check("post_rst_s_ready", s_ready, 1);
  endtask

  logic [7:0] frame1[$] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                            8'h93, 8'h00, 8'h10, 8'h00, 8'hC0};

  initial begin
    // Test 1: two instruction words, good checksum
    do_reset(1);
    push(1, 12'h000, 32'h0050_0013);
    push(1, 12'h004, 32'h0010_0093);
    send_frame(frame1, 0);
    repeat (2) @(posedge clk); #1;
    check("t1_load_err", load_err, 0);
    check("t1_pc_stall", pc_stall, 1);

    // Test 2: one data word then RUN
    do_reset(0);
    push(0, 12'h000, 32'h0000_0001);
    send_frame('{8'h5A, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01}, 0);
    send(8'hC3, 0);
    check("t2_pc_stall", pc_stall, 0);
    check("t2_load_done", load_done, 1);
    check("t2_s_ready", s_ready, 0);

    // Test 3: bad checksum; word still written, later RUN ignored
    do_reset(0);
    push(1, 12'h000, 32'hDEAD_BEEF);
    send_frame('{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00}, 0);
    check("t3_load_err", load_err, 1);
    check("t3_pc_stall", pc_stall, 1);
    send(8'hC3, 0);
    check("t3_run_ignored", {pc_stall, load_done}, 2'b10);

    // Test 4: count 1025 exceeds I-BRAM depth
    do_reset(0);
    send_frame('{8'hA5, 8'h01, 8'h04}, 0);
    check("t4_load_err", load_err, 1);
    check("t4_s_ready_err", s_ready, 1);

    // Test 5: empty frame, then RUN; then a stray byte after reset
    do_reset(0);
    send_frame('{8'hA5, 8'h00, 8'h00, 8'h00}, 0);
    check("t5_no_err", load_err, 0);
    send(8'hC3, 0);
    check("t5_run", {pc_stall, load_done, load_err}, 3'b010);
    do_reset(0);
    send(8'h11, 0);
    check("t5_stray_err", {load_err, pc_stall}, 2'b11);

    // Test 6: reset mid-word, then test-1 frame with random gaps
    do_reset(0);
    send_frame('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00}, 0);
    #2 rst = 1'b0;
    #1;
    check("t6_mid_rst_ready", s_ready, 0);
    check("t6_mid_rst_enb", {i_w_enb, d_w_enb}, 0);
    do_reset(1);
    push(1, 12'h000, 32'h0050_0013);
    push(1, 12'h004, 32'h0010_0093);
    send_frame(frame1, 1);
    repeat (4) @(posedge clk); #1;
    check("t6_load_err", load_err, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
